operand_fetch_stage: RTL

- Decode-to-execute boundary stage that sits directly in front of the 64-bit, 32-entry register file.
- Drives the register file read addresses and captures both source operands into a valid/ready output register.
- Bypasses the same-cycle writeback value around the register file.
- Keeps a per-register busy scoreboard and stalls on RAW and WAW hazards until the in-flight writer writes back or is killed.

---
 rtl/operand_fetch_stage_pkg.sv | 25 ++
 rtl/operand_fetch_stage_if.sv | 59 +++++
 rtl/operand_fetch_stage_scoreboard.sv | 66 ++++++
 rtl/operand_fetch_stage.sv | 130 +++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
`default_nettype none
//============================================================================
// Module : operand_fetch_stage_pkg
// Brief  : Shared widths, register-file constants and helpers for the
//          operand fetch stage and its busy scoreboard.
// Rev    : 1.0 - initial release
//============================================================================
package operand_fetch_stage_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    // x0 is hardwired: never busy, always reads as zero.
    function automatic logic is_zero_reg(input reg_addr_t r);
        return (r == ZERO_REG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_stage_if.sv
`default_nettype none
//============================================================================
// Module : operand_fetch_stage_if
// Brief  : Decode input, register-file read/writeback, kill/flush and
//          execute-side output bundle of the operand fetch stage.
// Rev    : 1.0 - initial release
//============================================================================
interface operand_fetch_stage_if;
    import operand_fetch_stage_pkg::*;

    // decode side
    logic      in_valid;
    logic      in_ready;
    reg_addr_t in_rs1;
    reg_addr_t in_rs2;
    reg_addr_t in_rd;
    logic      in_rd_we;
    // register file read port
    reg_addr_t rf_raddr1;
    reg_addr_t rf_raddr2;
    xlen_t     rf_rdata1;
    xlen_t     rf_rdata2;
    // writeback / squash / flush
    logic      wb_valid;
    reg_addr_t wb_rd;
    xlen_t     wb_data;
    logic      kill_valid;
    reg_addr_t kill_rd;
    logic      flush;
    // execute side
    logic      out_valid;
    logic      out_ready;
    xlen_t     out_rs1_data;
    xlen_t     out_rs2_data;
    reg_addr_t out_rd;
    logic      out_rd_we;

    // view of the stage itself
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        input  rf_rdata1, rf_rdata2,
        input  wb_valid, wb_rd, wb_data, kill_valid, kill_rd, flush,
        input  out_ready,
        output in_ready, rf_raddr1, rf_raddr2,
        output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we
    );

    // view of the surrounding pipeline / register file
    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        output rf_rdata1, rf_rdata2,
        output wb_valid, wb_rd, wb_data, kill_valid, kill_rd, flush,
        output out_ready,
        input  in_ready, rf_raddr1, rf_raddr2,
        input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we
    );

endinterface
`default_nettype wire

// File: rtl/operand_fetch_stage_scoreboard.sv
`default_nettype none
//============================================================================
// Module : operand_scoreboard
// Brief  : One busy bit per architectural register. Set on issue of a
//          writer, cleared on writeback, kill or flush of the held writer.
//          Provides RAW (rs1/rs2) and WAW (rd) hazard lookups.
// Rev    : 1.0 - initial release
//============================================================================
module operand_scoreboard
    import operand_fetch_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set_en_i,
    input  reg_addr_t set_rd_i,
    input  logic      wb_clr_en_i,
    input  reg_addr_t wb_clr_rd_i,
    input  logic      kill_clr_en_i,
    input  reg_addr_t kill_clr_rd_i,
    input  logic      flush_clr_en_i,
    input  reg_addr_t flush_clr_rd_i,
    input  reg_addr_t rs1_i,
    input  reg_addr_t rs2_i,
    input  reg_addr_t rd_i,
    input  logic      rd_we_i,
    output logic      rs1_hz_o,
    output logic      rs2_hz_o,
    output logic      waw_hz_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] pend_clr;

    // Registers retiring or squashed this cycle; they no longer block issue.
    always_comb begin
        pend_clr = '0;
        if (wb_clr_en_i)   pend_clr[wb_clr_rd_i]   = 1'b1;
        if (kill_clr_en_i) pend_clr[kill_clr_rd_i] = 1'b1;
        pend_clr[ZERO_REG] = 1'b0;
    end

    // Next busy vector: clears first, then the new writer's set wins.
    always_comb begin
        busy_d = busy_q & ~pend_clr;
        if (flush_clr_en_i && !is_zero_reg(flush_clr_rd_i))
            busy_d[flush_clr_rd_i] = 1'b0;
        if (set_en_i && !is_zero_reg(set_rd_i))
            busy_d[set_rd_i] = 1'b1;
    end

    // Busy vector storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Hazard lookups; a register cleared this cycle is already free.
    always_comb begin
        rs1_hz_o = !is_zero_reg(rs1_i) && busy_q[rs1_i] && !pend_clr[rs1_i];
        rs2_hz_o = !is_zero_reg(rs2_i) && busy_q[rs2_i] && !pend_clr[rs2_i];
        waw_hz_o = rd_we_i && !is_zero_reg(rd_i) && busy_q[rd_i] && !pend_clr[rd_i];
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
//============================================================================
// Module : operand_fetch_stage
// Brief  : Decode-to-execute boundary. Reads both sources from the register
//          file with same-cycle writeback bypass, stalls on RAW/WAW hazards
//          via the busy scoreboard and holds operands in a valid/ready
//          output register.
// Rev    : 1.0 - initial release
//============================================================================
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_stage_if.slave bus
);

    logic      rs1_hz;
    logic      rs2_hz;
    logic      waw_hz;
    logic      in_ready;
    logic      accept;
    logic      flush_clr;
    xlen_t     rs1_sel;
    xlen_t     rs2_sel;

    logic      out_valid_q;
    logic      out_valid_d;
    xlen_t     out_rs1_data_q;
    xlen_t     out_rs1_data_d;
    xlen_t     out_rs2_data_q;
    xlen_t     out_rs2_data_d;
    reg_addr_t out_rd_q;
    reg_addr_t out_rd_d;
    logic      out_rd_we_q;
    logic      out_rd_we_d;

    // The register file writes at the clock edge, so a same-cycle writeback
    // must be forwarded around its stale read data.
    function automatic xlen_t select_operand(
        input reg_addr_t rs,
        input xlen_t     rf_data,
        input logic      wb_valid,
        input reg_addr_t wb_rd,
        input xlen_t     wb_data
    );
        if (is_zero_reg(rs))               return '0;
        else if (wb_valid && (wb_rd == rs)) return wb_data;
        else                               return rf_data;
    endfunction

    operand_scoreboard u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_en_i       (accept && bus.in_rd_we),
        .set_rd_i       (bus.in_rd),
        .wb_clr_en_i    (bus.wb_valid),
        .wb_clr_rd_i    (bus.wb_rd),
        .kill_clr_en_i  (bus.kill_valid),
        .kill_clr_rd_i  (bus.kill_rd),
        .flush_clr_en_i (flush_clr),
        .flush_clr_rd_i (out_rd_q),
        .rs1_i          (bus.in_rs1),
        .rs2_i          (bus.in_rs2),
        .rd_i           (bus.in_rd),
        .rd_we_i        (bus.in_rd_we),
        .rs1_hz_o       (rs1_hz),
        .rs2_hz_o       (rs2_hz),
        .waw_hz_o       (waw_hz)
    );

    // Issue control and operand bypass selection.
    always_comb begin
        in_ready  = !bus.flush && !rs1_hz && !rs2_hz && !waw_hz &&
                    (!out_valid_q || bus.out_ready);
        accept    = bus.in_valid && in_ready;
        flush_clr = bus.flush && out_valid_q && out_rd_we_q;
        rs1_sel   = select_operand(bus.in_rs1, bus.rf_rdata1,
                                   bus.wb_valid, bus.wb_rd, bus.wb_data);
        rs2_sel   = select_operand(bus.in_rs2, bus.rf_rdata2,
                                   bus.wb_valid, bus.wb_rd, bus.wb_data);
    end

    // Output register next state: load on accept, drop valid on consume or
    // flush, otherwise hold every field.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        out_rd_d       = out_rd_q;
        out_rd_we_d    = out_rd_we_q;
        if (accept) begin
            out_valid_d    = 1'b1;
            out_rs1_data_d = rs1_sel;
            out_rs2_data_d = rs2_sel;
            out_rd_d       = bus.in_rd;
            out_rd_we_d    = bus.in_rd_we;
        end else if (bus.flush || (out_valid_q && bus.out_ready)) begin
            out_valid_d    = 1'b0;
        end
    end

    // Output register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            out_rd_q       <= '0;
            out_rd_we_q    <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            out_rd_q       <= out_rd_d;
            out_rd_we_q    <= out_rd_we_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.rf_raddr1    = bus.in_rs1;
    assign bus.rf_raddr2    = bus.in_rs2;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_rs1_data = out_rs1_data_q;
    assign bus.out_rs2_data = out_rs2_data_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_rd_we    = out_rd_we_q;

endmodule
`default_nettype wire
